// File: rtl/unidade_controle_pkg.sv
// Shared definitions for the accumulator processor control unit: FSM states,
// ALU operation codes, address-mux selects and one-hot op/mode bit positions.
package pacote_controle;

    typedef enum logic [2:0] {
        INICIO   = 3'd0,
        BUSCA    = 3'd1,
        DECOD    = 3'd2,
        INDIRETO = 3'd3,
        OPERANDO = 3'd4,
        EXECUTA  = 3'd5,
        ESCRITA  = 3'd6,
        PARADO   = 3'd7
    } estado_t;

    localparam logic [2:0] ULA_PASSA = 3'b000;
    localparam logic [2:0] ULA_SOMA  = 3'b001;
    localparam logic [2:0] ULA_SUB   = 3'b010;
    localparam logic [2:0] ULA_AND   = 3'b011;
    localparam logic [2:0] ULA_OR    = 3'b100;
    localparam logic [2:0] ULA_NOT   = 3'b101;
    localparam logic [2:0] ULA_SHR   = 3'b110;
    localparam logic [2:0] ULA_SHL   = 3'b111;

    localparam logic [1:0] END_PC  = 2'b00;
    localparam logic [1:0] END_RI  = 2'b01;
    localparam logic [1:0] END_RDM = 2'b10;

    localparam int OP_NOP = 15;
    localparam int OP_STA = 14;
    localparam int OP_LDA = 13;
    localparam int OP_ADD = 12;
    localparam int OP_SUB = 11;
    localparam int OP_AND = 10;
    localparam int OP_OR  = 9;
    localparam int OP_NOT = 8;
    localparam int OP_J   = 7;
    localparam int OP_JN  = 6;
    localparam int OP_JZ  = 5;
    localparam int OP_IN  = 4;
    localparam int OP_OUT = 3;
    localparam int OP_SHR = 2;
    localparam int OP_SHL = 1;
    localparam int OP_HLT = 0;

    localparam int MODO_DIR = 3;
    localparam int MODO_IND = 2;
    localparam int MODO_IM  = 1;
    localparam int MODO_SOP = 0;

endpackage

// File: rtl/unidade_controle_contador_timeout.sv
// Memory-handshake watchdog: counts consecutive cycles a request waits for its
// ack and flags the cycle in which the wait reaches LIMITE.
module contador_timeout #(
    parameter int LIMITE = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic memReq,
    input  logic memAck,
    output logic estouro
);

    logic [15:0] contagem;

    always_ff @(posedge clk) begin
        if (!rst_n || !memReq || memAck) begin
            contagem <= 16'd0;
        end else if (contagem != 16'hFFFF) begin
            contagem <= contagem + 16'd1;
        end
    end

    // Fires on the LIMITE-th waiting cycle so the FSM leaves right after it.
    assign estouro = memReq && !memAck && (contagem == 16'(LIMITE - 1));

endmodule

// File: rtl/unidade_controle.sv
// Multi-cycle control unit of the 16-bit accumulator processor.
// Define CONTROLE_TIMEOUT_EN to add a watchdog on memory requests.
module unidade_controle
    import pacote_controle::*;
#(
    parameter int TIMEOUT_CICLOS = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] op,
    input  logic [3:0]  modo,
    input  logic        flag_n,
    input  logic        flag_z,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [1:0]  sel_end,
    output logic        carga_ri,
    output logic        inc_pc,
    output logic        carga_pc,
    output logic        sel_pc,
    output logic        carga_rdm,
    output logic        carga_ac,
    output logic        carga_nz,
    output logic        carga_saida,
    output logic        sel_b,
    output logic        sel_entrada,
    output logic [2:0]  ula_op,
    output logic        parado,
    output logic        erro,
    output estado_t     estado
);

    // Handshake: mem_req/mem_we/sel_end hold from request until the edge that
    // samples mem_ack=1; mem_ack is only looked at in states that request.
    estado_t    proximoEstado;
    logic       erroProx;
    logic [2:0] ulaReg, ulaDecod;
    logic       saltoReg, staReg, viaIndireto, imediato;
    logic       estouro;

    logic opValido, modoValido, ehUla, ehUnario, ehSalto, saltoTomado;
    assign opValido    = $onehot(op);
    assign modoValido  = $onehot(modo);
    assign ehUla       = op[OP_LDA] | op[OP_ADD] | op[OP_SUB] | op[OP_AND] | op[OP_OR];
    assign ehUnario    = op[OP_NOT] | op[OP_SHR] | op[OP_SHL];
    assign ehSalto     = op[OP_J] | op[OP_JN] | op[OP_JZ];
    assign saltoTomado = op[OP_J] | (op[OP_JN] & flag_n) | (op[OP_JZ] & flag_z);

    always_comb begin
        ulaDecod = ULA_PASSA;
        if (op[OP_ADD])      ulaDecod = ULA_SOMA;
        else if (op[OP_SUB]) ulaDecod = ULA_SUB;
        else if (op[OP_AND]) ulaDecod = ULA_AND;
        else if (op[OP_OR])  ulaDecod = ULA_OR;
        else if (op[OP_NOT]) ulaDecod = ULA_NOT;
        else if (op[OP_SHR]) ulaDecod = ULA_SHR;
        else if (op[OP_SHL]) ulaDecod = ULA_SHL;
    end

`ifdef CONTROLE_TIMEOUT_EN
    contador_timeout #(.LIMITE(TIMEOUT_CICLOS)) uTimeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .memReq  (mem_req),
        .memAck  (mem_ack),
        .estouro (estouro)
    );
`else
    // No watchdog: a request waits forever (the comparison is constant false).
    assign estouro = (TIMEOUT_CICLOS < 0);
`endif

    // State register plus the path flags captured while decoding.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado      <= INICIO;
            erro        <= 1'b0;
            ulaReg      <= ULA_PASSA;
            saltoReg    <= 1'b0;
            staReg      <= 1'b0;
            viaIndireto <= 1'b0;
            imediato    <= 1'b0;
        end else begin
            estado <= proximoEstado;
            erro   <= erroProx;
            if (estado == DECOD) begin
                ulaReg      <= ulaDecod;
                saltoReg    <= ehSalto;
                staReg      <= op[OP_STA];
                viaIndireto <= (proximoEstado == INDIRETO);
                imediato    <= (proximoEstado == EXECUTA) && ehUla;
            end
        end
    end

    always_comb begin
        proximoEstado = estado;
        erroProx      = erro;
        case (estado)
            INICIO: proximoEstado = BUSCA;
            BUSCA:  if (mem_ack) proximoEstado = DECOD;
            DECOD: begin
                if (!opValido) begin
                    proximoEstado = PARADO;
                    erroProx      = 1'b1;
                end else if (op[OP_NOP] || op[OP_IN] || op[OP_OUT]) begin
                    proximoEstado = BUSCA;
                end else if (op[OP_HLT]) begin
                    proximoEstado = PARADO;
                end else if (ehUnario) begin
                    proximoEstado = EXECUTA;
                end else if (ehSalto && !saltoTomado) begin
                    proximoEstado = BUSCA;
                end else if (modoValido && modo[MODO_DIR]) begin
                    proximoEstado = ehUla ? OPERANDO : (op[OP_STA] ? ESCRITA : BUSCA);
                end else if (modoValido && modo[MODO_IND]) begin
                    proximoEstado = INDIRETO;
                end else if (modoValido && modo[MODO_IM] && ehUla) begin
                    proximoEstado = EXECUTA;
                end else begin
                    proximoEstado = PARADO;
                    erroProx      = 1'b1;
                end
            end
            INDIRETO: if (mem_ack) proximoEstado = saltoReg ? BUSCA : (staReg ? ESCRITA : OPERANDO);
            OPERANDO: if (mem_ack) proximoEstado = EXECUTA;
            EXECUTA:  proximoEstado = BUSCA;
            ESCRITA:  if (mem_ack) proximoEstado = BUSCA;
            PARADO:   proximoEstado = PARADO;
            default:  proximoEstado = INICIO;
        endcase
        if (estouro) begin
            proximoEstado = PARADO;
            erroProx      = 1'b1;
        end
    end

    always_comb begin
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        sel_end     = END_PC;
        carga_ri    = 1'b0;
        inc_pc      = 1'b0;
        carga_pc    = 1'b0;
        sel_pc      = 1'b0;
        carga_rdm   = 1'b0;
        carga_ac    = 1'b0;
        carga_nz    = 1'b0;
        carga_saida = 1'b0;
        sel_b       = 1'b0;
        sel_entrada = 1'b0;
        ula_op      = ULA_PASSA;
        parado      = 1'b0;
        case (estado)
            BUSCA: begin
                mem_req  = 1'b1;
                carga_ri = mem_ack;
                inc_pc   = mem_ack;
            end
            DECOD: if (opValido) begin
                carga_ac    = op[OP_IN];
                carga_nz    = op[OP_IN];
                sel_entrada = op[OP_IN];
                carga_saida = op[OP_OUT];
                carga_pc    = ehSalto && saltoTomado && modoValido && modo[MODO_DIR];
            end
            INDIRETO: begin
                mem_req   = 1'b1;
                sel_end   = END_RI;
                carga_pc  = mem_ack && saltoReg;
                sel_pc    = mem_ack && saltoReg;
                carga_rdm = mem_ack && !saltoReg;
            end
            OPERANDO: begin
                mem_req   = 1'b1;
                sel_end   = viaIndireto ? END_RDM : END_RI;
                carga_rdm = mem_ack;
            end
            EXECUTA: begin
                carga_ac = 1'b1;
                carga_nz = 1'b1;
                ula_op   = ulaReg;
                sel_b    = imediato;
            end
            ESCRITA: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                sel_end = viaIndireto ? END_RDM : END_RI;
            end
            PARADO:  parado = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_unidade_controle.sv
// Directed bench for unidade_controle: each task walks one instruction or fault
// scenario cycle by cycle and compares {estado, control lines} to hand values.
module tb_unidade_controle;
  import pacote_controle::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] op;
  logic [3:0]  modo;
  logic        flag_n, flag_z, mem_ack;
  logic        mem_req, mem_we, carga_ri, inc_pc, carga_pc, sel_pc, carga_rdm;
  logic        carga_ac, carga_nz, carga_saida, sel_b, sel_entrada, parado, erro;
  logic [1:0]  sel_end;
  logic [2:0]  ula_op;
  estado_t     estado;

  int tests_run = 0;
  int tests_failed = 0;
  logic [1:0]  exp_q[$];
  logic [1:0]  exp_sel;
  logic [21:0] exp_v;
  logic [18:0] ctrl;

  localparam logic [18:0] REQ  = 19'h40000;
  localparam logic [18:0] WE   = 19'h20000;
  localparam logic [18:0] SE_RDM = 19'h10000;
  localparam logic [18:0] SE_RI  = 19'h08000;
  localparam logic [18:0] RI   = 19'h04000;
  localparam logic [18:0] INC  = 19'h02000;
  localparam logic [18:0] CPC  = 19'h01000;
  localparam logic [18:0] SPC  = 19'h00800;
  localparam logic [18:0] RDM  = 19'h00400;
  localparam logic [18:0] CAC  = 19'h00200;
  localparam logic [18:0] CNZ  = 19'h00100;
  localparam logic [18:0] SAI  = 19'h00080;
  localparam logic [18:0] SELB = 19'h00040;
  localparam logic [18:0] SENT = 19'h00020;
  localparam logic [18:0] ULA_ADD_V = 19'h00004;
  localparam logic [18:0] ULA_NOT_V = 19'h00014;
  localparam logic [18:0] PAR  = 19'h00002;
  localparam logic [18:0] ERR  = 19'h00001;

  localparam logic [15:0] V_STA = 16'h4000;
  localparam logic [15:0] V_LDA = 16'h2000;
  localparam logic [15:0] V_ADD = 16'h1000;
  localparam logic [15:0] V_NOT = 16'h0100;
  localparam logic [15:0] V_JN  = 16'h0040;
  localparam logic [15:0] V_JZ  = 16'h0020;
  localparam logic [15:0] V_IN  = 16'h0010;
  localparam logic [15:0] V_OUT = 16'h0008;
  localparam logic [15:0] V_HLT = 16'h0001;
  localparam logic [3:0]  M_DIR = 4'b1000;
  localparam logic [3:0]  M_IND = 4'b0100;
  localparam logic [3:0]  M_IM  = 4'b0010;

  assign ctrl = {mem_req, mem_we, sel_end, carga_ri, inc_pc, carga_pc, sel_pc, carga_rdm,
                 carga_ac, carga_nz, carga_saida, sel_b, sel_entrada, ula_op, parado, erro};

  unidade_controle #(.TIMEOUT_CICLOS(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .modo(modo), .flag_n(flag_n), .flag_z(flag_z),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .sel_end(sel_end),
    .carga_ri(carga_ri), .inc_pc(inc_pc), .carga_pc(carga_pc), .sel_pc(sel_pc),
    .carga_rdm(carga_rdm), .carga_ac(carga_ac), .carga_nz(carga_nz),
    .carga_saida(carga_saida), .sel_b(sel_b), .sel_entrada(sel_entrada),
    .ula_op(ula_op), .parado(parado), .erro(erro), .estado(estado)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests_failed=%0d", tests_failed);
    $fatal(1, "bench time limit");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; mem_ack = 1'b0; op = 16'h0; modo = 4'h0; flag_n = 1'b0; flag_z = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ack = 1'b1; op = V_LDA; modo = M_DIR; flag_n = 1'b0; flag_z = 1'b0;
    tick(); tick();
    exp_v = {INICIO, 19'h0};
    tests_run++;
    if ({estado, ctrl} !== exp_v) begin tests_failed++; $display("FAIL reset_hold: got %h required %h", {estado, ctrl}, exp_v); end
    rst_n = 1'b1; mem_ack = 1'b0;
    tick(); #1;
    exp_v = {BUSCA, REQ};
    tests_run++;
    if ({estado, ctrl} !== exp_v) begin tests_failed++; $display("FAIL reset_busca: got %h required %h", {estado, ctrl}, exp_v); end
  endtask

  task automatic test_lda_dir();
    do_reset(); #1;
    exp_v = {INICIO, 19'h0};
    tests_run++;
    if ({estado, ctrl} !== exp_v) begin tests_failed++; $display("FAIL lda_inicio: got %h required %h", {estado, ctrl}, exp_v); end
    exp_q.push_back(END_PC);
    exp_q.push_back(END_RI);
    tick(); op = V_LDA; modo = M_DIR; mem_ack = 1'b1; #1;
    exp_v = {BUSCA, REQ | RI | INC};
    tests_run++;
    if ({estado, ctrl} !== exp_v) begin tests_failed++; $display("FAIL lda_busca: got %h required %h", {estado, ctrl}, exp_v); end
    exp_sel = exp_q.pop_front();
    tests_run++;
    if (sel_end !== exp_sel) begin tests_failed++; $display("FAIL lda_sel_end_fetch: got %b required %b", sel_end, exp_sel); end
    tick(); mem_ack = 1'b0; #1;
    exp_v = {DECOD, 19'h0};
    tests_run++;
    if ({estado, ctrl} !== exp_v) begin tests_failed++; $display("FAIL lda_decod: got %h required %h", {estado, ctrl}, exp_v); end
    tick(); mem_ack = 1'b1; #1;
    exp_v = {OPERANDO, REQ | SE_RI | RDM};
    tests_run++;
    if ({estado, ctrl} !== exp_v) begin tests_failed++; $display("FAIL lda_operando: got %h required %h", {estado, ctrl}, exp_v); end
    exp_sel = exp_q.pop_front();
    tests_run++;
    if (sel_end !== exp_sel) begin tests_failed++; $display("FAIL lda_sel_end_operand: got %b required %b", sel_end, exp_sel); end
    tick(); mem_ack = 1'b0; #1;
    exp_v = {EXECUTA, CAC | CNZ};
    tests_run++;
    if ({estado, ctrl} !== exp_v) begin tests_failed++; $display("FAIL lda_executa: got %h required %h", {estado, ctrl}, exp_v); end
    tick(); #1;
    exp_v = {BUSCA, REQ};
    tests_run++;
    if ({estado, ctrl} !== exp_v) begin tests_failed++; $display("FAIL lda_latency: got %h required %h", {estado, ctrl}, exp_v); end
  endtask

  task automatic test_alu_modes();
    do_reset();
    tick(); op = V_ADD; modo = M_IM; mem_ack = 1'b1;
    tick(); mem_ack = 1'b0;
    tick(); #1;
    exp_v = {EXECUTA, CAC | CNZ | SELB | ULA_ADD_V};
    tests_run++;
    if ({estado, ctrl} !== exp_v) begin tests_failed++; $display("FAIL add_im_executa: got %h required %h", {estado, ctrl}, exp_v); end
    tick(); op = V_LDA; modo = M_IND; mem_ack = 1'b1;
    tick(); mem_ack = 1'b0;
    tick(); mem_ack = 1'b1; #1;
    exp_v = {INDIRETO, REQ | SE_RI | RDM};
    tests_run++;
    if ({estado, ctrl} !== exp_v) begin tests_failed++; $display("FAIL lda_ind_indireto: got %h required %h", {estado, ctrl}, exp_v); end
    tick(); #1;
    exp_v = {OPERANDO, REQ | SE_RDM | RDM};
    tests_run++;
    if ({estado, ctrl} !== exp_v) begin tests_failed++; $display("FAIL lda_ind_operando: got %h required %h", {estado, ctrl}, exp_v); end
    tick(); mem_ack = 1'b0; #1;
    exp_v = {EXECUTA, CAC | CNZ};
    tests_run++;
    if ({estado, ctrl} !== exp_v) begin tests_failed++; $display("FAIL lda_ind_executa: got %h required %h", {estado, ctrl}, exp_v); end
  endtask

  task automatic test_unary_io();
    do_reset();
    tick(); op = V_NOT; modo = 4'h0; mem_ack = 1'b1;
    tick(); mem_ack = 1'b0;
    tick(); #1;
    exp_v = {EXECUTA, CAC | CNZ | ULA_NOT_V};
    tests_run++;
    if ({estado, ctrl} !== exp_v) begin tests_failed++; $display("FAIL not_executa: got %h required %h", {estado, ctrl}, exp_v); end
    tick(); op = V_IN; mem_ack = 1'b1;
    tick(); mem_ack = 1'b0; #1;
    exp_v = {DECOD, CAC | CNZ | SENT};
    tests_run++;
    if ({estado, ctrl} !== exp_v) begin tests_failed++; $display("FAIL in_decod: got %h required %h", {estado, ctrl}, exp_v); end
    tick(); op = V_OUT; mem_ack = 1'b1;
    tick(); mem_ack = 1'b0; #1;
    exp_v = {DECOD, SAI};
    tests_run++;
    if ({estado, ctrl} !== exp_v) begin tests_failed++; $display("FAIL out_decod: got %h required %h", {estado, ctrl}, exp_v); end
    tick(); #1;
    exp_v = {BUSCA, REQ};
    tests_run++;
    if ({estado, ctrl} !== exp_v) begin tests_failed++; $display("FAIL out_latency: got %h required %h", {estado, ctrl}, exp_v); end
  endtask

  task automatic test_jumps();
    do_reset();
    flag_z = 1'b1;
    tick(); op = V_JZ; modo = M_IND; mem_ack = 1'b1;
    tick(); mem_ack = 1'b0; #1;
    exp_v = {DECOD, 19'h0};
    tests_run++;
    if ({estado, ctrl} !== exp_v) begin tests_failed++; $display("FAIL jz_ind_decod: got %h required %h", {estado, ctrl}, exp_v); end
    tick(); mem_ack = 1'b1; #1;
    exp_v = {INDIRETO, REQ | SE_RI | CPC | SPC};
    tests_run++;
    if ({estado, ctrl} !== exp_v) begin tests_failed++; $display("FAIL jz_ind_indireto: got %h required %h", {estado, ctrl}, exp_v); end
    tick(); mem_ack = 1'b0; #1;
    exp_v = {BUSCA, REQ};
    tests_run++;
    if ({estado, ctrl} !== exp_v) begin tests_failed++; $display("FAIL jz_ind_busca: got %h required %h", {estado, ctrl}, exp_v); end
    flag_z = 1'b0; mem_ack = 1'b1;
    tick(); mem_ack = 1'b0; #1;
    exp_v = {DECOD, 19'h0};
    tests_run++;
    if ({estado, ctrl} !== exp_v) begin tests_failed++; $display("FAIL jz_not_taken_decod: got %h required %h", {estado, ctrl}, exp_v); end
    tick(); #1;
    exp_v = {BUSCA, REQ};
    tests_run++;
    if ({estado, ctrl} !== exp_v) begin tests_failed++; $display("FAIL jz_not_taken_busca: got %h required %h", {estado, ctrl}, exp_v); end
    flag_n = 1'b1; op = V_JN; modo = M_DIR; mem_ack = 1'b1;
    tick(); mem_ack = 1'b0; #1;
    exp_v = {DECOD, CPC};
    tests_run++;
    if ({estado, ctrl} !== exp_v) begin tests_failed++; $display("FAIL jn_dir_decod: got %h required %h", {estado, ctrl}, exp_v); end
  endtask

  task automatic test_sta_ind_wait();
    do_reset();
    tick(); op = V_STA; modo = M_IND; mem_ack = 1'b1;
    tick(); mem_ack = 1'b0;
    tick(); mem_ack = 1'b1; #1;
    exp_v = {INDIRETO, REQ | SE_RI | RDM};
    tests_run++;
    if ({estado, ctrl} !== exp_v) begin tests_failed++; $display("FAIL sta_ind_indireto: got %h required %h", {estado, ctrl}, exp_v); end
    tick();
    for (int i = 0; i < 3; i++) begin
      mem_ack = 1'b0; #1;
      exp_v = {ESCRITA, REQ | WE | SE_RDM};
      tests_run++;
      if ({estado, ctrl} !== exp_v) begin tests_failed++; $display("FAIL sta_wait_%0d: got %h required %h", i, {estado, ctrl}, exp_v); end
      tick();
    end
    mem_ack = 1'b1; #1;
    exp_v = {ESCRITA, REQ | WE | SE_RDM};
    tests_run++;
    if ({estado, ctrl} !== exp_v) begin tests_failed++; $display("FAIL sta_ack: got %h required %h", {estado, ctrl}, exp_v); end
    tick(); mem_ack = 1'b0; #1;
    exp_v = {BUSCA, REQ};
    tests_run++;
    if ({estado, ctrl} !== exp_v) begin tests_failed++; $display("FAIL sta_after_ack: got %h required %h", {estado, ctrl}, exp_v); end
  endtask

  task automatic test_faults();
    do_reset();
    tick(); op = 16'h0; modo = M_DIR; mem_ack = 1'b1;
    tick(); mem_ack = 1'b0;
    tick(); #1;
    exp_v = {PARADO, PAR | ERR};
    tests_run++;
    if ({estado, ctrl} !== exp_v) begin tests_failed++; $display("FAIL op_zero_parado: got %h required %h", {estado, ctrl}, exp_v); end
    op = V_LDA; mem_ack = 1'b1;
    repeat (4) tick();
    #1;
    tests_run++;
    if ({estado, ctrl} !== exp_v) begin tests_failed++; $display("FAIL op_zero_sticky: got %h required %h", {estado, ctrl}, exp_v); end
    do_reset(); #1;
    exp_v = {INICIO, 19'h0};
    tests_run++;
    if ({estado, ctrl} !== exp_v) begin tests_failed++; $display("FAIL erro_reset_clears: got %h required %h", {estado, ctrl}, exp_v); end
    tick(); op = V_STA; modo = M_IM; mem_ack = 1'b1;
    tick(); mem_ack = 1'b0;
    tick(); tick(); tick(); #1;
    exp_v = {PARADO, PAR | ERR};
    tests_run++;
    if ({estado, ctrl} !== exp_v) begin tests_failed++; $display("FAIL sta_im_sticky: got %h required %h", {estado, ctrl}, exp_v); end
    do_reset();
    tick(); op = V_HLT; modo = 4'h0; mem_ack = 1'b1;
    tick(); mem_ack = 1'b0;
    tick(); #1;
    exp_v = {PARADO, PAR};
    tests_run++;
    if ({estado, ctrl} !== exp_v) begin tests_failed++; $display("FAIL hlt_parado: got %h required %h", {estado, ctrl}, exp_v); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick(); tick(); #1;
    exp_v = {BUSCA, REQ};
    tests_run++;
    if ({estado, ctrl} !== exp_v) begin tests_failed++; $display("FAIL mid_busca_wait: got %h required %h", {estado, ctrl}, exp_v); end
    rst_n = 1'b0;
    tick(); rst_n = 1'b1; #1;
    exp_v = {INICIO, 19'h0};
    tests_run++;
    if ({estado, ctrl} !== exp_v) begin tests_failed++; $display("FAIL mid_inicio: got %h required %h", {estado, ctrl}, exp_v); end
    tick(); #1;
    exp_v = {BUSCA, REQ};
    tests_run++;
    if ({estado, ctrl} !== exp_v) begin tests_failed++; $display("FAIL mid_busca_again: got %h required %h", {estado, ctrl}, exp_v); end
  endtask

  task automatic test_timeout();
    do_reset();
    tick();
`ifdef CONTROLE_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_v = {BUSCA, REQ};
      tests_run++;
      if ({estado, ctrl} !== exp_v) begin tests_failed++; $display("FAIL timeout_wait_%0d: got %h required %h", i, {estado, ctrl}, exp_v); end
      tick();
    end
    #1;
    exp_v = {PARADO, PAR | ERR};
    tests_run++;
    if ({estado, ctrl} !== exp_v) begin tests_failed++; $display("FAIL timeout_parado: got %h required %h", {estado, ctrl}, exp_v); end
`else
    repeat (1000) tick();
    #1;
    exp_v = {BUSCA, REQ};
    tests_run++;
    if ({estado, ctrl} !== exp_v) begin tests_failed++; $display("FAIL no_timeout_busca: got %h required %h", {estado, ctrl}, exp_v); end
`endif
  endtask

  // sequence and final report
  initial begin
    test_reset();
    test_lda_dir();
    test_alu_modes();
    test_unary_io();
    test_jumps();
    test_sta_ind_wait();
    test_faults();
    test_reset_mid();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/unidade_controle.md
# unidade_controle

Multi-cycle control unit for the 16-bit accumulator processor. It consumes the decoder's one-hot operation and addressing-mode strobes plus the N/Z flags, sequences fetch, operand access, execute and write-back, and drives the datapath and memory-handshake control lines. It sits directly downstream of the instruction decoder and upstream of the datapath registers, ALU and memory interface.

## Interface
- `TIMEOUT_CICLOS`, default 255: maximum cycles `mem_req` may wait for `mem_ack`. Used only with the timeout macro.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `op` in 16: one-hot operation from the decoder, MSB..LSB = NOP, STA, LDA, ADD, SUB, AND, OR, NOT, J, JN, JZ, IN, OUT, SHR, SHL, HLT.
- `modo` in 4: one-hot addressing mode, MSB..LSB = DIR, IND, IM, SOP.
- `flag_n`, `flag_z` in 1 each: accumulator flags.
- `mem_ack` in 1: memory completion. On a read, data is valid in the same cycle.
- `mem_req`, `mem_we` out 1 each: memory request and write qualifier.
- `sel_end` out 2: address mux select. 00 = PC, 01 = RI operand field [8:0], 10 = RDM.
- `carga_ri`, `inc_pc`, `carga_pc` out 1 each: register loads.
- `sel_pc` out 1: PC load source. 0 = operand field, 1 = memory data.
- `carga_rdm`, `carga_ac`, `carga_nz`, `carga_saida` out 1 each: register loads.
- `sel_b` out 1: ALU B operand. 0 = RDM, 1 = immediate.
- `sel_entrada` out 1: AC source is the input port instead of the ALU.
- `ula_op` out 3: ALU operation code.
- `parado` out 1: processor halted.
- `erro` out 1: halt was caused by a fault.

## Operation
- States are INICIO, BUSCA, DECOD, INDIRETO, OPERANDO, EXECUTA, ESCRITA, PARADO.
- Reset enters INICIO. Every output is 0 in INICIO. INICIO always moves to BUSCA on the next cycle.
- BUSCA:
  - Drives `mem_req=1`, `sel_end=00`.
  - On `mem_ack`, pulses `carga_ri` and `inc_pc`, then goes to DECOD.
- DECOD: `op` and `modo` are sampled here.
  - `op` not exactly one-hot goes to PARADO with `erro=1`.
  - NOP goes to BUSCA.
  - HLT goes to PARADO.
  - NOT, SHR and SHL go to EXECUTA.
  - IN asserts `carga_ac`, `carga_nz` and `sel_entrada`, then goes to BUSCA.
  - OUT asserts `carga_saida`, then goes to BUSCA.
  - For all other ops the mode is ignored except as follows:
    - LDA, ADD, SUB, AND, OR: DIR goes to OPERANDO. IND goes to INDIRETO. IM goes to EXECUTA with `sel_b=1`. SOP goes to PARADO with `erro`.
    - STA: DIR goes to ESCRITA. IND goes to INDIRETO. IM and SOP go to PARADO with `erro`.
    - J, JN, JZ, condition taken (J always, JN if `flag_n`, JZ if `flag_z`):
      - DIR asserts `carga_pc`, `sel_pc=0`, then goes to BUSCA.
      - IND goes to INDIRETO.
      - IM and SOP go to PARADO with `erro`.
    - J, JN, JZ, condition not taken: go to BUSCA. PC was already incremented.
- INDIRETO:
  - Drives `mem_req`, `sel_end=01`.
  - On `mem_ack`: jumps assert `carga_pc` with `sel_pc=1` and go to BUSCA. Other ops assert `carga_rdm` and go to OPERANDO, or to ESCRITA for STA.
- OPERANDO:
  - Drives `mem_req`.
  - `sel_end` is 10 if the path came through INDIRETO, otherwise 01.
  - On `mem_ack`, asserts `carga_rdm` and goes to EXECUTA.
- EXECUTA:
  - Asserts `carga_ac` and `carga_nz` with `ula_op` selected by op: LDA 000 (pass B), ADD 001, SUB 010, AND 011, OR 100, NOT 101, SHR 110, SHL 111.
  - Then goes to BUSCA.
- ESCRITA:
  - Drives `mem_req`, `mem_we` and `sel_end` (10 after INDIRETO, else 01).
  - On `mem_ack`, goes to BUSCA.
- PARADO:
  - Asserts `parado`.
  - `erro` holds its value.
  - All other outputs are 0.
  - Exits only on reset.

## Timing
- Handshake:
  - `mem_req`, `mem_we` and `sel_end` stay stable from request until the edge where `mem_ack=1` is sampled.
  - `mem_req` is 0 in the cycle after the ack.
  - `mem_ack` sampled while `mem_req=0` is ignored.
- With a zero-wait memory (ack in the first request cycle), instruction latencies are:
  - NOP: 2 cycles.
  - IN, OUT, not-taken jump, DIR jump: 2 cycles.
  - NOT, SHR, SHL, IM ALU ops: 3 cycles.
  - STA DIR: 3 cycles.
  - LDA/ALU DIR: 4 cycles.
  - IND jump: 3 cycles. IND ALU op: 5 cycles. STA IND: 4 cycles.
  - Each wait cycle adds 1.
- Reset asserted mid-handshake: the next state is INICIO and `mem_req` drops the following cycle. The memory must discard the abandoned request.
- `erro` and the state register are the only sequential outputs. All other outputs are decoded from state plus registered path flags.

## Configuration
- `CONTROLE_TIMEOUT_EN` defined:
  - A wait counter clears on every cycle with `mem_req=0` or `mem_ack=1`, and increments otherwise.
  - When the count reaches `TIMEOUT_CICLOS`, the next state is PARADO with `erro=1`.
- Undefined: no counter is present, and a request waits indefinitely.

## Structure
- Shared package `pacote_controle` holds:
  - the state enum,
  - the `ula_op` constants,
  - the `sel_end` constants,
  - the op/mode bit-index constants.
- Sub-module `contador_timeout` holds the wait counter. It is instantiated only under the macro.

## Test plan
- Reset, then LDA DIR at PC 0 with operand 0x05 and zero-wait memory. Required: outputs all 0 in INICIO; `sel_end` sequence 00, 01; EXECUTA with `ula_op=000`, `carga_ac=1`; BUSCA reached 4 cycles after INICIO exits.
- JZ IND with `flag_z=1` and memory[0x10]=0x3A. Required: INDIRETO asserts `carga_pc`, `sel_pc=1`. Same instruction with `flag_z=0`: returns to BUSCA after DECOD, no `carga_pc`.
- STA IND with a 3-cycle ack delay in ESCRITA. Required: `mem_we=1` and `sel_end=10` held for 3 cycles; `mem_req=0` in the cycle after ack.
- `op`=0 (no bit set) in DECOD, and separately STA with IM. Required: PARADO with `parado=1`, `erro=1`; both stick until `rst_n=0`.
- `rst_n` low during a BUSCA wait. Required: INICIO next with all outputs 0, then BUSCA.
- Macro defined, `TIMEOUT_CICLOS`=4, `mem_ack` held 0. Required: `erro=1` and PARADO after 4 wait cycles. Macro undefined: still in BUSCA after 1000 cycles.
